// File: rtl/spi_ram_target.sv
// SPI RAM responder backed by an on-chip byte array, with SPI pins oversampled on clk.
// Define SPI_RAM_TARGET_QUAD_EN to add the 0xEB quad read and 0x38 quad write opcodes.
module spi_ram_target #(
   parameter int unsigned MEM_DEPTH  = 4096,
   parameter logic [23:0] ID_VALUE   = 24'h0D5D52,
   parameter int unsigned FAST_DUMMY = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         spi_cs_n,
   input  logic                         spi_sclk,
   input  logic [3:0]                   spi_io_in,
   output logic [3:0]                   spi_io_out,
   output logic [3:0]                   spi_io_oe,
   input  logic                         load_en,
   input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
   input  logic [7:0]                   load_data,
   output logic                         busy,
   output logic                         cmd_err
);
   localparam int unsigned AW = $clog2(MEM_DEPTH);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, ID, IGNORE} state_t;

   state_t        state;
   logic [7:0]    mem [MEM_DEPTH];
   logic [2:0]    cs_sync, sclk_sync;
   logic [3:0]    io_s0, io_s1;
   logic [7:0]    bit_cnt, sh_in, sh_out, wr_byte;
   logic [AW-1:0] addr;
   logic [1:0]    id_idx;
   logic          load_pend, wr_pend, op_write, op_fast;
   logic          quad;

`ifndef SPI_RAM_TARGET_QUAD_EN
   assign quad = 1'b0;
`endif

   logic          rise, fall, cs_fall, cs_rise;
   logic [7:0]    opcode, sh_in_next, sh_out_next, byte_last, addr_last, dummy_last, id_next;
   logic [AW-1:0] addr_next;
   logic [3:0]    drive, oe_read;

   assign cs_fall     = ~cs_sync[1] & cs_sync[2];
   assign cs_rise     = cs_sync[1] & ~cs_sync[2];
   assign rise        = sclk_sync[1] & ~sclk_sync[2];
   assign fall        = ~sclk_sync[1] & sclk_sync[2];
   assign opcode      = {sh_in[6:0], io_s1[0]};
   assign sh_in_next  = quad ? {sh_in[3:0], io_s1} : opcode;
   assign sh_out_next = quad ? {sh_out[3:0], 4'h0} : {sh_out[6:0], 1'b0};
   assign addr_next   = quad ? {addr[AW-5:0], io_s1} : {addr[AW-2:0], io_s1[0]};
   assign drive       = quad ? sh_out[7:4] : {2'b00, sh_out[7], 1'b0};
   assign oe_read     = quad ? 4'b1111 : 4'b0010;
   assign byte_last   = quad ? 8'd1 : 8'd7;
   assign addr_last   = quad ? 8'd5 : 8'd23;
   assign dummy_last  = quad ? 8'd5 : 8'(FAST_DUMMY - 1);

   always_comb begin
      unique case (id_idx)
         2'd0:    id_next = ID_VALUE[15:8];
         2'd1:    id_next = ID_VALUE[7:0];
         default: id_next = 8'h00;
      endcase
   end

   // Chains reset to "cs asserted" so a cs_n held low across reset never looks like a new frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync   <= 3'b000;
         sclk_sync <= 3'b000;
         io_s0     <= 4'h0;
         io_s1     <= 4'h0;
      end else begin
         cs_sync   <= {cs_sync[1:0], spi_cs_n};
         sclk_sync <= {sclk_sync[1:0], spi_sclk};
         io_s0     <= spi_io_in;
         io_s1     <= io_s0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_pend) begin
         mem[addr] <= wr_byte;
      end else if (load_en && cs_sync[1]) begin
         mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         spi_io_out <= 4'h0;
         spi_io_oe  <= 4'h0;
         busy       <= 1'b0;
         cmd_err    <= 1'b0;
         bit_cnt    <= 8'd0;
         sh_in      <= 8'h00;
         sh_out     <= 8'h00;
         wr_byte    <= 8'h00;
         addr       <= '0;
         id_idx     <= 2'd0;
         load_pend  <= 1'b0;
         wr_pend    <= 1'b0;
         op_write   <= 1'b0;
         op_fast    <= 1'b0;
`ifdef SPI_RAM_TARGET_QUAD_EN
         quad       <= 1'b0;
`endif
      end else begin
         cmd_err   <= 1'b0;
         wr_pend   <= 1'b0;
         load_pend <= 1'b0;
         if (wr_pend) addr <= addr + 1'b1;
         if (load_pend) sh_out <= mem[addr];
         if (cs_rise) begin
            state      <= IDLE;
            spi_io_out <= 4'h0;
            spi_io_oe  <= 4'h0;
            busy       <= 1'b0;
            bit_cnt    <= 8'd0;
            sh_in      <= 8'h00;
            sh_out     <= 8'h00;
            id_idx     <= 2'd0;
`ifdef SPI_RAM_TARGET_QUAD_EN
            quad       <= 1'b0;
`endif
         end else if (state == IDLE) begin
            if (cs_fall) begin
               state   <= CMD;
               busy    <= 1'b1;
               bit_cnt <= 8'd0;
            end
         end else if (rise) begin
            unique case (state)
               CMD: begin
                  sh_in   <= sh_in_next;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 8'd7) begin
                     bit_cnt <= 8'd0;
                     unique case (opcode)
                        8'h03: begin state <= ADDR; op_write <= 1'b0; op_fast <= 1'b0; end
                        8'h0B: begin state <= ADDR; op_write <= 1'b0; op_fast <= 1'b1; end
                        8'h02: begin state <= ADDR; op_write <= 1'b1; op_fast <= 1'b0; end
                        8'h9F: begin
                           state     <= ID;
                           sh_out    <= ID_VALUE[23:16];
                           id_idx    <= 2'd0;
                           spi_io_oe <= 4'b0010;
                        end
`ifdef SPI_RAM_TARGET_QUAD_EN
                        8'hEB: begin
                           state <= ADDR; op_write <= 1'b0; op_fast <= 1'b1; quad <= 1'b1;
                        end
                        8'h38: begin
                           state <= ADDR; op_write <= 1'b1; op_fast <= 1'b0; quad <= 1'b1;
                        end
`endif
                        default: begin
                           state   <= IGNORE;
                           cmd_err <= 1'b1;
                        end
                     endcase
                  end
               end
               ADDR: begin
                  addr    <= addr_next;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == addr_last) begin
                     bit_cnt <= 8'd0;
                     if (op_write) begin
                        state <= WDATA;
                     end else if (op_fast) begin
                        state <= DUMMY;
                     end else begin
                        state     <= RDATA;
                        load_pend <= 1'b1;
                        spi_io_oe <= oe_read;
                     end
                  end
               end
               DUMMY: begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == dummy_last) begin
                     bit_cnt   <= 8'd0;
                     state     <= RDATA;
                     load_pend <= 1'b1;
                     spi_io_oe <= oe_read;
                  end
               end
               WDATA: begin
                  sh_in   <= sh_in_next;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == byte_last) begin
                     bit_cnt <= 8'd0;
                     wr_pend <= 1'b1;
                     wr_byte <= sh_in_next;
                  end
               end
               default: ;
            endcase
         end else if (fall && (state == RDATA || state == ID)) begin
            spi_io_out <= drive;
            sh_out     <= sh_out_next;
            bit_cnt    <= bit_cnt + 1'b1;
            if (bit_cnt == byte_last) begin
               bit_cnt <= 8'd0;
               if (state == RDATA) begin
                  addr      <= addr + 1'b1;
                  load_pend <= 1'b1;
               end else begin
                  sh_out <= id_next;
                  if (id_idx != 2'd3) id_idx <= id_idx + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_ram_target.sv
// Randomized self-checking bench for spi_ram_target: a byte-array memory model predicts read data,
// ID bytes, output enables and cmd_err pulses.
module tb_spi_ram_target;
   localparam int unsigned DEPTH = 4096;

   logic        clk = 1'b0, rst = 1'b1, cs_n = 1'b0, sclk = 1'b0, load_en = 1'b0;
   logic [3:0]  io_in = 4'h0;
   logic [3:0]  io_out, io_oe;
   logic [11:0] load_addr = 12'h000;
   logic [7:0]  load_data = 8'h00;
   logic        busy, cmd_err;

   spi_ram_target #(.MEM_DEPTH(DEPTH), .ID_VALUE(24'h0D5D52), .FAST_DUMMY(8)) dut (
      .clk(clk), .rst(rst), .spi_cs_n(cs_n), .spi_sclk(sclk), .spi_io_in(io_in),
      .spi_io_out(io_out), .spi_io_oe(io_oe), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .busy(busy), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   logic [7:0] mm [DEPTH];
   logic [7:0] tx_buf [8];
   logic [7:0] rx_buf [8];
   int         n_chk = 0, n_pass = 0, err_cnt = 0, exp_err = 0;
   bit         exp_busy = 1'b0, quiet = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endfunction

   function automatic logic [7:0] id_byte(input int i);
      return (i == 0) ? 8'h0D : (i == 1) ? 8'h5D : (i == 2) ? 8'h52 : 8'h00;
   endfunction

   function automatic bit supported(input logic [7:0] op);
`ifdef SPI_RAM_TARGET_QUAD_EN
      if (op == 8'hEB || op == 8'h38) return 1'b1;
`endif
      return op == 8'h03 || op == 8'h0B || op == 8'h02 || op == 8'h9F;
   endfunction

   // Per-cycle monitor: cmd_err must be a single-clock pulse; unused lanes stay quiet.
   logic cmd_err_prev = 1'b0;
   initial forever begin
      @(negedge clk);
      if (cmd_err) begin
         err_cnt++;
         chk("cmd_err_width", {31'd0, cmd_err_prev}, 32'd0);
      end
`ifndef SPI_RAM_TARGET_QUAD_EN
      chk("unused_out_lanes", {29'd0, io_out[3:2], io_out[0]}, 32'd0);
      chk("unused_oe_lanes", {29'd0, io_oe[3:2], io_oe[0]}, 32'd0);
`endif
      cmd_err_prev = cmd_err;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input logic [3:0] oe_exp, output logic r);
      logic [2:0] junk;
      junk  = 3'($urandom);
      io_in = {junk, b};
      wait_clk(5);
      chk("oe", io_oe, oe_exp);
      chk("busy", busy, exp_busy);
      if (quiet) chk("quiet_out", io_out, 4'h0);
      r    = io_out[1];
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic [3:0] oe_exp, output logic [7:0] r);
      logic rb;
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i], oe_exp, rb);
         r[i] = rb;
      end
   endtask

   task automatic end_txn();
      cs_n = 1'b1;
      wait_clk(6);
      chk("idle_oe", io_oe, 4'h0);
      chk("idle_out", io_out, 4'h0);
      chk("idle_busy", busy, 1'b0);
      chk("cmd_err_count", err_cnt, exp_err);
   endtask

   task automatic txn(input logic [7:0] op, input logic [23:0] a, input bit has_addr,
                      input int ndummy, input int nbytes, input int tail, input bit rd);
      logic [7:0] r, ab;
      logic       rb;
      exp_busy = 1'b1;
      cs_n     = 1'b0;
      wait_clk(5);
      send_byte(op, 4'h0, r);
      if (has_addr) for (int i = 2; i >= 0; i--) begin
         ab = a[8*i +: 8];
         send_byte(ab, 4'h0, r);
      end
      for (int i = 0; i < ndummy; i++) send_bit(1'b0, 4'h0, rb);
      for (int i = 0; i < nbytes; i++) begin
         send_byte(tx_buf[i], rd ? 4'b0010 : 4'b0000, r);
         rx_buf[i] = r;
      end
      for (int i = 0; i < tail; i++) send_bit(1'($urandom), 4'h0, rb);
      end_txn();
   endtask

   task automatic do_write(input logic [23:0] a, input int n, input int tail);
      logic [11:0] idx;
      for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
      txn(8'h02, a, 1'b1, 0, n, tail, 1'b0);
      for (int i = 0; i < n; i++) begin
         idx     = a[11:0] + 12'(i);
         mm[idx] = tx_buf[i];
      end
   endtask

   task automatic do_read(input bit fast, input logic [23:0] a, input int n);
      logic [11:0] idx;
      for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
      txn(fast ? 8'h0B : 8'h03, a, 1'b1, fast ? 8 : 0, n, 0, 1'b1);
      for (int i = 0; i < n; i++) begin
         idx = a[11:0] + 12'(i);
         chk(fast ? "fast_read_data" : "read_data", rx_buf[i], mm[idx]);
      end
   endtask

   task automatic do_id(input int n);
      for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
      txn(8'h9F, 24'h0, 1'b0, 0, n, 0, 1'b1);
      for (int i = 0; i < n; i++) chk("id_data", rx_buf[i], id_byte(i));
   endtask

`ifdef SPI_RAM_TARGET_QUAD_EN
   task automatic send_nib(input logic [3:0] n, input logic [3:0] oe_exp, output logic [3:0] r);
      io_in = n;
      wait_clk(5);
      chk("quad_oe", io_oe, oe_exp);
      chk("busy", busy, exp_busy);
      r    = io_out;
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
   endtask

   task automatic quad_txn(input logic [7:0] op, input logic [23:0] a, input int n, input bit rd);
      logic [7:0] r;
      logic [3:0] nb, rh, rl;
      exp_busy = 1'b1;
      cs_n     = 1'b0;
      wait_clk(5);
      send_byte(op, 4'h0, r);
      for (int i = 5; i >= 0; i--) begin
         nb = a[4*i +: 4];
         send_nib(nb, 4'h0, rh);
      end
      if (rd) for (int i = 0; i < 6; i++) send_nib(4'h0, 4'h0, rh);
      for (int i = 0; i < n; i++) begin
         r = tx_buf[i];
         send_nib(r[7:4], rd ? 4'hF : 4'h0, rh);
         send_nib(r[3:0], rd ? 4'hF : 4'h0, rl);
         rx_buf[i] = {rh, rl};
      end
      end_txn();
   endtask
`endif

   initial begin
      logic [7:0]  r, op;
      logic        rb;
      logic [23:0] a;
      logic [11:0] idx;
      int          kind, n;

      // Reset held with cs_n low and SCLK toggling: everything stays quiet.
      quiet    = 1'b1;
      exp_busy = 1'b0;
      send_byte(8'hFF, 4'h0, r);
      rst = 1'b0;
      // cs_n still low after release: a full read frame must be ignored.
      send_byte(8'h03, 4'h0, r);
      send_byte(8'h00, 4'h0, r);
      send_byte(8'h00, 4'h0, r);
      send_byte(8'h10, 4'h0, r);
      send_byte(8'h00, 4'h0, r);
      end_txn();
      quiet = 1'b0;

      // Backdoor preload of the whole array, mirrored into the model.
      for (int i = 0; i < DEPTH; i++) begin
         load_en   = 1'b1;
         load_addr = 12'(i);
         load_data = (i == 32) ? 8'h3C : (i == 48) ? 8'h81 : 8'($urandom);
         mm[i]     = load_data;
         @(negedge clk);
      end
      load_en = 1'b0;

      // Write A5 5A at 0x10 and read it back.
      tx_buf[0] = 8'hA5;
      tx_buf[1] = 8'h5A;
      txn(8'h02, 24'h000010, 1'b1, 0, 2, 0, 1'b0);
      mm[16] = 8'hA5;
      mm[17] = 8'h5A;
      txn(8'h03, 24'h000010, 1'b1, 0, 2, 0, 1'b1);
      chk("lit_read_a5", rx_buf[0], 8'hA5);
      chk("lit_read_5a", rx_buf[1], 8'h5A);

      // Wrap at the top of memory.
      tx_buf[0] = 8'h11;
      tx_buf[1] = 8'h22;
      txn(8'h02, 24'h000FFF, 1'b1, 0, 2, 0, 1'b0);
      mm[4095] = 8'h11;
      mm[0]    = 8'h22;
      txn(8'h03, 24'h000000, 1'b1, 0, 1, 0, 1'b1);
      chk("lit_wrap_read", rx_buf[0], 8'h22);
      txn(8'h0B, 24'h000FFF, 1'b1, 8, 1, 0, 1'b1);
      chk("lit_fast_read", rx_buf[0], 8'h11);

      // ID read with trailing zero.
      txn(8'h9F, 24'h0, 1'b0, 0, 4, 0, 1'b1);
      chk("lit_id0", rx_buf[0], 8'h0D);
      chk("lit_id1", rx_buf[1], 8'h5D);
      chk("lit_id2", rx_buf[2], 8'h52);
      chk("lit_id3", rx_buf[3], 8'h00);

      // Unsupported opcode, then a normal read still works.
      exp_err++;
      txn(8'h55, 24'h0, 1'b0, 0, 1, 0, 1'b0);
      txn(8'h03, 24'h000010, 1'b1, 0, 1, 0, 1'b1);
      chk("lit_read_after_err", rx_buf[0], 8'hA5);

      // Partial byte is discarded.
      txn(8'h02, 24'h000020, 1'b1, 0, 0, 4, 1'b0);
      txn(8'h03, 24'h000020, 1'b1, 0, 1, 0, 1'b1);
      chk("lit_partial_write", rx_buf[0], 8'h3C);

      // Backdoor load is ignored while cs_n is low.
      cs_n = 1'b0;
      wait_clk(4);
      load_en   = 1'b1;
      load_addr = 12'h030;
      load_data = 8'h77;
      wait_clk(1);
      load_en = 1'b0;
      end_txn();
      txn(8'h03, 24'h000030, 1'b1, 0, 1, 0, 1'b1);
      chk("lit_backdoor_blocked", rx_buf[0], 8'h81);

`ifdef SPI_RAM_TARGET_QUAD_EN
      tx_buf[0] = 8'hC3;
      quad_txn(8'h38, 24'h000040, 1, 1'b0);
      mm[64] = 8'hC3;
      quad_txn(8'hEB, 24'h000040, 1, 1'b1);
      chk("lit_quad_roundtrip", rx_buf[0], 8'hC3);
`endif

      // Randomized traffic against the model.
      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 5);
         n    = $urandom_range(1, 5);
         a    = 24'($urandom);
         if ($urandom_range(0, 2) == 0) a[11:0] = 12'hFFF - 12'($urandom_range(0, 3));
         unique case (kind)
            0: begin
               do_write(a, n, 0);
               do_read(1'($urandom), a, n);
            end
            1: do_read(1'b0, a, n);
            2: do_read(1'b1, a, n);
            3: do_id(n);
            4: begin
               op = 8'($urandom);
               while (supported(op)) op = 8'($urandom);
               for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
               exp_err++;
               txn(op, a, 1'b0, 0, n, 0, 1'b0);
            end
            default: begin
               do_write(a, n, $urandom_range(1, 7));
               do_read(1'b0, a, n + 1);
            end
         endcase
      end

`ifdef SPI_RAM_TARGET_QUAD_EN
      for (int t = 0; t < 6; t++) begin
         n = $urandom_range(1, 4);
         a = 24'($urandom);
         for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
         quad_txn(8'h38, a, n, 1'b0);
         for (int i = 0; i < n; i++) begin
            idx     = a[11:0] + 12'(i);
            mm[idx] = tx_buf[i];
         end
         quad_txn(8'hEB, a, n, 1'b1);
         for (int i = 0; i < n; i++) begin
            idx = a[11:0] + 12'(i);
            chk("quad_read_data", rx_buf[i], mm[idx]);
         end
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
